uart_tx: RTL and testbench

//  Asynchronous serial transmitter (UART TX). Accepts a parallel word on a
//  one-cycle start request and shifts it out LSB-first on txd as start bit,

---
 rtl/uart_tx.sv | 143 ++++++++++++++
 tb/tb_uart_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: LSB-first asynchronous serial transmitter with
// optional parity bit and one or two stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 9,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] txd_data,
  input  logic       txd_start,
  output logic       txd,
  output logic       busy
);

  localparam int BW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [8:0] MASK =
    9'((10'd1 << DATA_BITS) - 10'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          bit_end;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    bit_end = (baud_q == BAUD_MAX);

    if (state_q != S_IDLE)
      baud_d = bit_end ? '0 : baud_q + BW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (txd_start) begin
          state_d = S_START;
          shift_d = txd_data & MASK;
          par_d   = (^(txd_data & MASK)) ^ PARITY_ODD;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
          txd_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: frame-level checks of uart_tx in four
// configurations (default, even/odd parity, two stop bits).
module tb_uart_tx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start_v;
  logic [8:0] data_v [4];
  logic [3:0] txd_w;
  logic [3:0] busy_w;

  int tests = 0;
  int fails = 0;
  bit exp_q[$];

  typedef struct {
    int         u;
    logic [8:0] d;
    bit         hold;
    int         poke;
  } vec_t;

  vec_t vt[10];

  always #5 clk = ~clk;

  uart_tx u_def (
    .clk(clk), .rst_n(rst_n),
    .txd_data(data_v[0]), .txd_start(start_v[0]),
    .txd(txd_w[0]), .busy(busy_w[0])
  );

  uart_tx #(.PARITY_EN(1'b1)) u_pe (
    .clk(clk), .rst_n(rst_n),
    .txd_data(data_v[1]), .txd_start(start_v[1]),
    .txd(txd_w[1]), .busy(busy_w[1])
  );

  uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_po (
    .clk(clk), .rst_n(rst_n),
    .txd_data(data_v[2]), .txd_start(start_v[2]),
    .txd(txd_w[2]), .busy(busy_w[2])
  );

  uart_tx #(.STOP_BITS(2)) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .txd_data(data_v[3]), .txd_start(start_v[3]),
    .txd(txd_w[3]), .busy(busy_w[3])
  );

  function automatic int pe_of(int u);
    return (u == 1 || u == 2) ? 1 : 0;
  endfunction

  function automatic int odd_of(int u);
    return (u == 2) ? 1 : 0;
  endfunction

  function automatic int sb_of(int u);
    return (u == 3) ? 2 : 1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic push_frame(int u, logic [8:0] d);
    bit p;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe_of(u) != 0)
      exp_q.push_back(p ^ (odd_of(u) != 0));
    for (int i = 0; i < sb_of(u); i++)
      exp_q.push_back(1'b1);
  endtask

  task automatic run_frame(int v, int u, logic [8:0] d,
                           bit hold, int poke);
    int f;
    int n;
    int b;
    bit eb;
    f = CPB * (1 + 9 + pe_of(u) + sb_of(u));
    exp_q.delete();
    push_frame(u, d);
    data_v[u]  = d;
    start_v[u] = 1'b1;
    @(posedge clk);
    #1;
    start_v[u] = hold;
    data_v[u]  = 9'($urandom);
    n = 0;
    b = 0;
    for (int c = 0; c < f + 40; c++) begin
      @(negedge clk);
      if (c == 0)
        chk($sformatf("v%0d_start_edge", v),
            int'(txd_w[u]), 0);
      if (!busy_w[u]) break;
      n++;
      if (c == poke) begin
        start_v[u] = 1'b1;
        data_v[u]  = 9'h1FF;
      end else if (c == poke + 1) begin
        start_v[u] = hold;
      end
      if (c % CPB == CPB / 2 && exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        chk($sformatf("v%0d_bit%0d", v, b),
            int'(txd_w[u]), int'(eb));
        b++;
      end
    end
    chk($sformatf("v%0d_busy_len", v), n, f);
    chk($sformatf("v%0d_bits_left", v),
        int'(exp_q.size()), 0);
    chk($sformatf("v%0d_idle_txd", v),
        int'(txd_w[u]), 1);
  endtask

  initial begin
    logic [8:0] d;

    vt[0] = '{0, 9'h065, 1'b0, -1};
    vt[1] = '{0, 9'h0A5, 1'b0, 100};
    vt[2] = '{1, 9'h065, 1'b0, -1};
    vt[3] = '{2, 9'h065, 1'b0, -1};
    vt[4] = '{1, 9'h000, 1'b0, -1};
    vt[5] = '{2, 9'h1A3, 1'b0, -1};
    vt[6] = '{0, 9'h000, 1'b1, -1};
    vt[7] = '{0, 9'h1FF, 1'b0, -1};
    vt[8] = '{3, 9'h000, 1'b1, -1};
    vt[9] = '{3, 9'h1FF, 1'b0, -1};

    rst_n   = 1'b0;
    start_v = 4'hF;
    for (int i = 0; i < 4; i++) data_v[i] = 9'h1FF;
    @(negedge clk);
    @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("rst_txd%0d", u), int'(txd_w[u]), 1);
      chk($sformatf("rst_busy%0d", u), int'(busy_w[u]), 0);
    end
    rst_n   = 1'b1;
    start_v = 4'h0;
    @(negedge clk);
    for (int u = 0; u < 4; u++)
      chk($sformatf("post_rst_busy%0d", u),
          int'(busy_w[u]), 0);

    for (int i = 0; i < 10; i++) begin
      run_frame(i, vt[i].u, vt[i].d, vt[i].hold, vt[i].poke);
      if (vt[i].poke >= 0) begin
        repeat (2 * CPB) @(negedge clk);
        chk($sformatf("v%0d_no_queue", i),
            int'(busy_w[vt[i].u]), 0);
      end
    end

    d          = 9'h065;
    data_v[0]  = d;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (89) @(negedge clk);
    chk("mid_bit4", int'(txd_w[0]), int'(d[4]));
    chk("mid_busy", int'(busy_w[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_txd", int'(txd_w[0]), 1);
    chk("abort_busy", int'(busy_w[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", int'(busy_w[0]), 0);
    run_frame(10, 0, 9'h1C3, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
